// File: rtl/pump_pkg.sv
// Shared constants, FSM state encoding and the latched command record
// used by the pump scheduler slice.
package pump_pkg;

  localparam logic [31:0] FLASHMEM_BASE_ADDR = 32'hA000_0000;
  localparam logic [31:0] PUMP_BASE_ADDR     = 32'hA001_0000;
  localparam logic [31:0] PUMP_CLR_ADDR      = PUMP_BASE_ADDR + 32'd12;

  localparam logic [31:0] PUMP_IN  = 32'hF0F0_F0F0;
  localparam logic [31:0] PUMP_OUT = 32'h0F0F_0F0F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_CHECK,
    S_ISSUE,
    S_RUN,
    S_ABORT,
    S_CMPL
  } sched_state_t;

  typedef struct packed {
    logic        dir;
    logic [31:0] id;
    logic [31:0] addr;
    logic [31:0] size;
  } pump_cmd_t;

endpackage

// File: rtl/pump_scheduler_if.sv
// Requester-side command/completion bundle for the pump scheduler.
// The master side is the set of snapshot requesters, the slave side is the scheduler.
interface pump_req_if #(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_dir;
  logic [NUM_REQ*32-1:0] req_id;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_size;
  logic [NUM_REQ-1:0]    cmp_valid;
  logic [NUM_REQ-1:0]    cmp_err;

  modport master (
    output req_valid, req_dir, req_id, req_addr, req_size,
    input  req_ready, cmp_valid, cmp_err
  );

  modport slave (
    input  req_valid, req_dir, req_id, req_addr, req_size,
    output req_ready, cmp_valid, cmp_err
  );

endinterface

// File: rtl/pump_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       any
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] gnt_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   gnt_rot;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NUM_REQ-1:0];
    gnt_rot = req_rot & (~req_rot + NUM_REQ'(1));
    gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    grant   = gnt_dbl[2*NUM_REQ-1:NUM_REQ];
    any     = |req;
  end

endmodule

// File: rtl/pump_scheduler.sv
// Shares the single pump engine among NUM_REQ requesters: arbitrates, validates,
// drives the pump, snoops its write bus for clear/final writes, and guards it with a watchdog.
module pump_scheduler
  import pump_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned NUM_SLOTS   = 8,
  parameter logic [31:0] SLOT_BYTES  = 32'h2000,
  parameter int unsigned TIMEOUT_CYC = 65536,
  parameter int unsigned ABORT_CYC   = 4
) (
  input  logic        clk,
  input  logic        rst,
  pump_req_if.slave   req,
  output logic [31:0] FlashMem_id,
  output logic [31:0] pump_addr,
  output logic [31:0] pump_size,
  output logic [31:0] pump_controller,
  output logic        pump_abort,
  input  logic        snp_wr_en,
  input  logic [31:0] snp_wr_addr,
  input  logic        snp_wr_done,
  output logic        busy
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  sched_state_t       state, state_next;
  logic [PW-1:0]      rr_ptr, gnt_idx;
  logic [NUM_REQ-1:0] gnt, gnt_q;
  logic               gnt_any;
  pump_cmd_t          cmd;
  logic [31:0]        end_addr, end_calc;
  logic [31:0]        snp_addr_q;
  logic [31:0]        wd_cnt, abort_cnt;
  logic               err_q, cmd_bad;
  logic               clr_done, end_done, wd_expired, abort_last;

  logic [NUM_REQ-1:0] ready_q, ready_d, cmp_valid_q, cmp_valid_d, cmp_err_q, cmp_err_d;
  logic [31:0]        id_d, addr_d, size_d, ctrl_d;
  logic               abort_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req.req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .any   (gnt_any)
  );

  assign req.req_ready = ready_q;
  assign req.cmp_valid = cmp_valid_q;
  assign req.cmp_err   = cmp_err_q;
  assign busy          = (state != S_IDLE);

  assign clr_done   = snp_wr_done && (snp_addr_q == PUMP_CLR_ADDR);
  assign end_done   = snp_wr_done && (snp_addr_q == end_addr) && (snp_addr_q != PUMP_CLR_ADDR);
  assign wd_expired = (wd_cnt == TIMEOUT_CYC - 1);
  assign abort_last = (abort_cnt == ABORT_CYC - 1);

  // Binary index of the one-hot grant, used for rr_ptr and field selection.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (gnt == (NUM_REQ'(1) << i)) gnt_idx = PW'(i);
  end

  // Command validation and end address of the final pump write (32-bit wrap).
  always_comb begin
    cmd_bad  = (cmd.size == '0) || (cmd.size[1:0] != 2'b00) || (cmd.size > SLOT_BYTES) ||
               (cmd.id >= NUM_SLOTS) || (cmd.addr[1:0] != 2'b00);
    end_calc = cmd.dir ? (FLASHMEM_BASE_ADDR + cmd.id * SLOT_BYTES + cmd.size)
                       : (cmd.addr + cmd.size);
  end

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      ready_q         <= '0;
      cmp_valid_q     <= '0;
      cmp_err_q       <= '0;
      FlashMem_id     <= '0;
      pump_addr       <= '0;
      pump_size       <= '0;
      pump_controller <= '0;
      pump_abort      <= 1'b0;
    end else begin
      state           <= state_next;
      ready_q         <= ready_d;
      cmp_valid_q     <= cmp_valid_d;
      cmp_err_q       <= cmp_err_d;
      FlashMem_id     <= id_d;
      pump_addr       <= addr_d;
      pump_size       <= size_d;
      pump_controller <= ctrl_d;
      pump_abort      <= abort_d;
    end
  end

  // Next-state logic; a clear or final write beats a same-cycle watchdog expiry.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (|req.req_valid) state_next = S_ARB;
      S_ARB:   state_next = gnt_any ? S_CHECK : S_IDLE;
      S_CHECK: state_next = cmd_bad ? S_CMPL : S_ISSUE;
      S_ISSUE: begin
        if (clr_done)        state_next = S_RUN;
        else if (wd_expired) state_next = S_ABORT;
      end
      S_RUN: begin
        if (end_done)        state_next = S_CMPL;
        else if (wd_expired) state_next = S_ABORT;
      end
      S_ABORT: if (abort_last) state_next = S_CMPL;
      S_CMPL:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; pump fields hold unless changed here.
  always_comb begin
    ready_d     = '0;
    cmp_valid_d = '0;
    cmp_err_d   = '0;
    id_d        = FlashMem_id;
    addr_d      = pump_addr;
    size_d      = pump_size;
    ctrl_d      = pump_controller;
    abort_d     = (state_next == S_ABORT);
    case (state)
      S_ARB: ready_d = gnt;
      S_CHECK: begin
        if (!cmd_bad) begin
          id_d   = cmd.id;
          addr_d = cmd.addr;
          size_d = cmd.size;
          ctrl_d = cmd.dir ? PUMP_IN : PUMP_OUT;
        end
      end
      S_ISSUE: if (clr_done) ctrl_d = '0;
      S_CMPL: begin
        cmp_valid_d = gnt_q;
        cmp_err_d   = err_q ? gnt_q : '0;
        id_d        = '0;
        addr_d      = '0;
        size_d      = '0;
        ctrl_d      = '0;
      end
      default: ;
    endcase
    if (state_next == S_ABORT) ctrl_d = '0;
  end

  // Command latch, round-robin pointer, snoop address, watchdog and abort timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      gnt_q      <= '0;
      cmd        <= '0;
      end_addr   <= '0;
      err_q      <= 1'b0;
      snp_addr_q <= '0;
      wd_cnt     <= '0;
      abort_cnt  <= '0;
    end else begin
      if (snp_wr_en) snp_addr_q <= snp_wr_addr;
      if (state == S_ARB && gnt_any) begin
        gnt_q     <= gnt;
        rr_ptr    <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
        cmd.dir   <= |(req.req_dir & gnt);
        cmd.id    <= 32'(req.req_id   >> {gnt_idx, 5'b0});
        cmd.addr  <= 32'(req.req_addr >> {gnt_idx, 5'b0});
        cmd.size  <= 32'(req.req_size >> {gnt_idx, 5'b0});
      end
      if (state == S_CHECK) begin
        err_q    <= cmd_bad;
        end_addr <= end_calc;
      end
      if (state_next == S_ABORT) err_q <= 1'b1;
      if (state == S_CHECK)
        wd_cnt <= '0;
      else if (state == S_ISSUE || state == S_RUN)
        wd_cnt <= wd_cnt + 32'd1;
      abort_cnt <= (state == S_ABORT) ? abort_cnt + 32'd1 : '0;
    end
  end

endmodule
